// File: rtl/card_lock_pkg.sv
// Shared widths, sentinel, record layout and reader FSM encoding for the card-lock datapath.
package card_lock_pkg;

    localparam int unsigned CODE_W      = 16;
    localparam int unsigned TYPE_W      = 2;
    localparam int unsigned SENT_W      = 4;
    localparam int unsigned PAYLOAD_W   = TYPE_W + CODE_W;
    localparam int unsigned TIMEOUT_CYC = 27000;
    localparam int unsigned TIMER_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BITCNT_W    = $clog2(PAYLOAD_W);
    localparam int unsigned STATE_W     = 3;

    localparam logic [SENT_W-1:0] SENTINEL = 4'b1011;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_ERROR   = 3'd5
    } reader_state_t;

    // Type travels first on the stripe, so it sits in the upper bits of the shifted payload.
    typedef struct packed {
        logic [TYPE_W-1:0] card_type;
        logic [CODE_W-1:0] code;
    } card_record_t;

endpackage

// File: rtl/card_stripe_reader_if.sv
// Head-side inputs and decoded record outputs of the stripe reader.
interface card_stripe_reader_if;
    import card_lock_pkg::*;

    logic                card_detect_n;
    logic                stripe_clk;
    logic                stripe_data;
    logic [CODE_W-1:0]   entry_code_on_card;
    logic [TYPE_W-1:0]   card_type;
    logic                card_read;
    logic                frame_error;
    logic [STATE_W-1:0]  reader_state;

    modport master (
        output card_detect_n, stripe_clk, stripe_data,
        input  entry_code_on_card, card_type, card_read, frame_error, reader_state
    );

    modport slave (
        input  card_detect_n, stripe_clk, stripe_data,
        output entry_code_on_card, card_type, card_read, frame_error, reader_state
    );

endinterface

// File: rtl/sync_edge_detect.sv
// 2-FF synchronizer for an asynchronous input, plus a one-cycle pulse on its synchronized rising edge.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_c
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= RESET_VAL;
            level <= RESET_VAL;
            prev  <= RESET_VAL;
        end else begin
            meta  <= din;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;

endmodule

// File: rtl/card_stripe_reader.sv
// Magnetic-stripe deserializer: hunts the start sentinel, shifts type+code, checks even parity
// and holds the decoded record while the card stays inserted.
module card_stripe_reader
    import card_lock_pkg::*;
(
    input  logic                 CLOCK_27,
    input  logic                 reset_n,
    card_stripe_reader_if.slave  bus
);

    logic card_detect_level;
    logic cd_rise_unused;
    logic strobe_level_unused;
    logic bit_stb_c;
    logic bit_val;
    logic data_rise_unused;

    // Detect input resets to "no card" so the FSM does not start hunting out of reset.
    sync_edge_detect #(.RESET_VAL(1'b1)) u_sync_detect (
        .clk    (CLOCK_27),
        .rst_n  (reset_n),
        .din    (bus.card_detect_n),
        .level  (card_detect_level),
        .rise_c (cd_rise_unused)
    );

    sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_strobe (
        .clk    (CLOCK_27),
        .rst_n  (reset_n),
        .din    (bus.stripe_clk),
        .level  (strobe_level_unused),
        .rise_c (bit_stb_c)
    );

    sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_data (
        .clk    (CLOCK_27),
        .rst_n  (reset_n),
        .din    (bus.stripe_data),
        .level  (bit_val),
        .rise_c (data_rise_unused)
    );

    reader_state_t          state;
    logic [SENT_W-1:0]      window;
    logic [PAYLOAD_W-1:0]   payload;
    logic [BITCNT_W-1:0]    bit_cnt;
    logic [TIMER_W-1:0]     timer;
    logic [CODE_W-1:0]      code_q;
    logic [TYPE_W-1:0]      type_q;
    logic                   card_read_q;
    logic                   frame_error_q;

    logic                   card_present_c;
    logic [SENT_W-1:0]      window_next_c;
    logic                   parity_ok_c;
    logic                   timeout_c;
    card_record_t           record_c;

    assign card_present_c = ~card_detect_level;
    assign window_next_c  = {window[SENT_W-2:0], bit_val};
    assign parity_ok_c    = ~(^{payload, bit_val});
    assign timeout_c      = (timer >= TIMER_W'(TIMEOUT_CYC - 1));
    assign record_c       = card_record_t'(payload);

    always_ff @(posedge CLOCK_27 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            window        <= '0;
            payload       <= '0;
            bit_cnt       <= '0;
            timer         <= '0;
            code_q        <= '0;
            type_q        <= '0;
            card_read_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else if (!card_present_c) begin
            // Removal beats any strobe on the same edge; frame_error survives until reinsertion.
            state       <= ST_IDLE;
            code_q      <= '0;
            type_q      <= '0;
            card_read_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state         <= ST_HUNT;
                    frame_error_q <= 1'b0;
                    window        <= '0;
                    payload       <= '0;
                    bit_cnt       <= '0;
                    timer         <= '0;
                end
                ST_HUNT: begin
                    if (bit_stb_c) begin
                        window <= window_next_c;
                        if (window_next_c == SENTINEL) begin
                            state   <= ST_PAYLOAD;
                            bit_cnt <= '0;
                            timer   <= '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_stb_c) begin
                        payload <= {payload[PAYLOAD_W-2:0], bit_val};
                        timer   <= '0;
                        if (bit_cnt == BITCNT_W'(PAYLOAD_W - 1)) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BITCNT_W'(1);
                        end
                    end else if (timeout_c) begin
                        state         <= ST_ERROR;
                        frame_error_q <= 1'b1;
                        timer         <= TIMER_W'(TIMEOUT_CYC);
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_stb_c) begin
                        timer <= '0;
                        if (parity_ok_c) begin
                            state       <= ST_HOLD;
                            code_q      <= record_c.code;
                            type_q      <= record_c.card_type;
                            card_read_q <= 1'b1;
                        end else begin
                            state         <= ST_ERROR;
                            frame_error_q <= 1'b1;
                        end
                    end else if (timeout_c) begin
                        state         <= ST_ERROR;
                        frame_error_q <= 1'b1;
                        timer         <= TIMER_W'(TIMEOUT_CYC);
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_HOLD: begin
                    card_read_q <= 1'b1;
                end
                ST_ERROR: begin
                    frame_error_q <= 1'b1;
                    card_read_q   <= 1'b0;
                    code_q        <= '0;
                    type_q        <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.entry_code_on_card = code_q;
    assign bus.card_type          = type_q;
    assign bus.card_read          = card_read_q;
    assign bus.frame_error        = frame_error_q;
    assign bus.reader_state       = state;

endmodule

// File: tb/tb_card_stripe_reader.sv
// Directed bench for card_stripe_reader: drives stripe records and compares decoded outputs
// against scoreboard entries computed from the stimulus.
module tb_card_stripe_reader;
    import card_lock_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    card_stripe_reader_if bus ();

    card_stripe_reader dut (
        .CLOCK_27 (clk),
        .reset_n  (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [2:0]  state;
        logic        rd;
        logic [15:0] code;
        logic [1:0]  typ;
        logic        ferr;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.stripe_data = b;
        bus.stripe_clk  = 1'b1;
        cycles(2);
        bus.stripe_clk  = 1'b0;
        cycles(2);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_head(input logic [1:0] typ, input logic [15:0] code);
        send_bits(32'(4'b1011), 4);
        send_bits(32'(typ), 2);
        send_bits(32'(code), 16);
    endtask

    function automatic int ones(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic even_bit(input logic [1:0] typ, input logic [15:0] code);
        return logic'(ones({14'b0, typ, code}) % 2);
    endfunction

    task automatic expect_record(input string tag, input logic [1:0] typ, input logic [15:0] code,
                                 input logic p);
        exp_t e;
        logic ok;
        ok      = ((ones({14'b0, typ, code}) + int'(p)) % 2) == 0;
        e.tag   = tag;
        e.state = ok ? 3'd4 : 3'd5;
        e.rd    = ok;
        e.code  = ok ? code : 16'h0;
        e.typ   = ok ? typ : 2'b00;
        e.ferr  = !ok;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int budget);
        exp_t e;
        for (int i = 0; i < budget; i++) begin
            if (bus.reader_state == sb[0].state) break;
            cycles(1);
        end
        e = sb.pop_front();
        check({e.tag, ".state"}, 32'(bus.reader_state), 32'(e.state));
        check({e.tag, ".card_read"}, 32'(bus.card_read), 32'(e.rd));
        check({e.tag, ".code"}, 32'(bus.entry_code_on_card), 32'(e.code));
        check({e.tag, ".type"}, 32'(bus.card_type), 32'(e.typ));
        check({e.tag, ".frame_error"}, 32'(bus.frame_error), 32'(e.ferr));
    endtask

    task automatic insert_card();
        bus.card_detect_n = 1'b0;
        cycles(4);
    endtask

    task automatic remove_card();
        bus.card_detect_n = 1'b1;
        cycles(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic p;
        rst_n             = 1'b0;
        bus.card_detect_n = 1'b1;
        bus.stripe_clk    = 1'b0;
        bus.stripe_data   = 1'b0;
        cycles(3);
        check("reset.state", 32'(bus.reader_state), 32'd0);
        check("reset.card_read", 32'(bus.card_read), 32'd0);
        check("reset.code", 32'(bus.entry_code_on_card), 32'd0);
        check("reset.type", 32'(bus.card_type), 32'd0);
        check("reset.frame_error", 32'(bus.frame_error), 32'd0);
        rst_n = 1'b1;
        cycles(4);
        check("idle_no_card.state", 32'(bus.reader_state), 32'd0);

        // Valid record BEEF / type 2
        insert_card();
        check("insert.state", 32'(bus.reader_state), 32'd1);
        p = even_bit(2'b10, 16'hBEEF);
        expect_record("t1_valid", 2'b10, 16'hBEEF, p);
        send_head(2'b10, 16'hBEEF);
        send_bit(p);
        pop_check(20);

        // Further strobes in HOLD must not disturb the record
        expect_record("t1_hold", 2'b10, 16'hBEEF, p);
        send_bits(32'h0000_00A5, 8);
        pop_check(1);

        // Removal: outputs still held after 2 clocks, cleared on the 3rd
        bus.card_detect_n = 1'b1;
        cycles(2);
        check("remove.before_3clk", 32'(bus.card_read), 32'd1);
        cycles(1);
        check("remove.card_read", 32'(bus.card_read), 32'd0);
        check("remove.code", 32'(bus.entry_code_on_card), 32'd0);
        check("remove.type", 32'(bus.card_type), 32'd0);
        check("remove.state", 32'(bus.reader_state), 32'd0);
        cycles(2);

        // Bad parity
        insert_card();
        p = ~even_bit(2'b10, 16'hBEEF);
        expect_record("t2_badpar", 2'b10, 16'hBEEF, p);
        send_head(2'b10, 16'hBEEF);
        send_bit(p);
        pop_check(20);

        // frame_error survives removal, clears only when the reinsertion reaches HUNT
        remove_card();
        check("err_after_remove", 32'(bus.frame_error), 32'd1);
        bus.card_detect_n = 1'b0;
        cycles(2);
        check("err_before_reinsert_edge", 32'(bus.frame_error), 32'd1);
        cycles(2);
        check("err_cleared_reinsert", 32'(bus.frame_error), 32'd0);

        // Noise before sentinel
        send_bits(32'(3'b001), 3);
        check("noise.still_hunt", 32'(bus.reader_state), 32'd1);
        p = even_bit(2'b01, 16'h1234);
        expect_record("t3_noise", 2'b01, 16'h1234, p);
        send_head(2'b01, 16'h1234);
        send_bit(p);
        pop_check(20);
        remove_card();

        // Removal arriving with the final parity bit: no latch
        insert_card();
        send_head(2'b11, 16'h5A5A);
        p = even_bit(2'b11, 16'h5A5A);
        bus.stripe_data   = p;
        bus.stripe_clk    = 1'b1;
        bus.card_detect_n = 1'b1;
        cycles(2);
        bus.stripe_clk = 1'b0;
        cycles(2);
        check("simul_remove.state", 32'(bus.reader_state), 32'd0);
        check("simul_remove.card_read", 32'(bus.card_read), 32'd0);
        check("simul_remove.code", 32'(bus.entry_code_on_card), 32'd0);

        // Timeout after 9 payload bits: ERROR exactly TIMEOUT_CYC clocks after the last capture
        insert_card();
        send_bits(32'(4'b1011), 4);
        send_bits(32'h0000_00C3, 8);
        bus.stripe_data = 1'b1;
        bus.stripe_clk  = 1'b1;
        cycles(2);
        bus.stripe_clk  = 1'b0;
        cycles(int'(TIMEOUT_CYC));
        check("timeout.one_before", 32'(bus.reader_state), 32'd2);
        cycles(1);
        check("timeout.state", 32'(bus.reader_state), 32'd5);
        check("timeout.frame_error", 32'(bus.frame_error), 32'd1);
        check("timeout.card_read", 32'(bus.card_read), 32'd0);
        remove_card();

        // Asynchronous reset mid-PAYLOAD
        insert_card();
        send_bits(32'(4'b1011), 4);
        send_bits(32'(5'b10110), 5);
        check("midframe.state", 32'(bus.reader_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.state", 32'(bus.reader_state), 32'd0);
        check("async_reset.card_read", 32'(bus.card_read), 32'd0);
        check("async_reset.frame_error", 32'(bus.frame_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5);
        check("post_reset.hunt", 32'(bus.reader_state), 32'd1);
        p = even_bit(2'b00, 16'h0001);
        expect_record("t6_after_reset", 2'b00, 16'h0001, p);
        send_head(2'b00, 16'h0001);
        send_bit(p);
        pop_check(20);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
